// File: rtl/tx_seq_pkg.sv
// Shared FSM states, frame-length defaults and 802.11a RATE / N_DBPS constants.
// The PAD state exists only when TX_SEQ_PAD_EN is defined.
package tx_seq_pkg;

    localparam int SERVICE_LEN_DEF = 16;
    localparam int TAIL_LEN_DEF    = 6;
    localparam int NDBPS_W         = 8;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    localparam logic [NDBPS_W-1:0] NDBPS_6M  = 8'd24;
    localparam logic [NDBPS_W-1:0] NDBPS_9M  = 8'd36;
    localparam logic [NDBPS_W-1:0] NDBPS_12M = 8'd48;
    localparam logic [NDBPS_W-1:0] NDBPS_18M = 8'd72;
    localparam logic [NDBPS_W-1:0] NDBPS_24M = 8'd96;
    localparam logic [NDBPS_W-1:0] NDBPS_36M = 8'd144;
    localparam logic [NDBPS_W-1:0] NDBPS_48M = 8'd192;
    localparam logic [NDBPS_W-1:0] NDBPS_54M = 8'd216;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVICE = 3'd1,
        DATA    = 3'd2,
        TAIL    = 3'd3,
`ifdef TX_SEQ_PAD_EN
        PAD     = 3'd4,
`endif
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/tx_rate_lut.sv
// Combinational 802.11a RATE code to N_DBPS lookup with a validity flag.
module tx_rate_lut
    import tx_seq_pkg::*;
(
    input  logic [3:0]         i_rate,
    output logic [NDBPS_W-1:0] o_ndbps,
    output logic               o_rate_ok
);

    always_comb begin
        o_ndbps   = '0;
        o_rate_ok = 1'b1;
        case (i_rate)
            RATE_6M:  o_ndbps = NDBPS_6M;
            RATE_9M:  o_ndbps = NDBPS_9M;
            RATE_12M: o_ndbps = NDBPS_12M;
            RATE_18M: o_ndbps = NDBPS_18M;
            RATE_24M: o_ndbps = NDBPS_24M;
            RATE_36M: o_ndbps = NDBPS_36M;
            RATE_48M: o_ndbps = NDBPS_48M;
            RATE_54M: o_ndbps = NDBPS_54M;
            default:  o_rate_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/tx_bit_sequencer.sv
// Serialises SERVICE zeros, PSDU bytes (LSB first) and tail zeros into one bit stream.
// Define TX_SEQ_PAD_EN to append zero padding up to a whole number of OFDM symbols.
module tx_bit_sequencer
    import tx_seq_pkg::*;
#(
    parameter int SERVICE_LEN = SERVICE_LEN_DEF,
    parameter int TAIL_LEN    = TAIL_LEN_DEF
) (
    input  logic        clk_Modulation,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  rate,
    input  logic [15:0] packetlength,
    input  logic        psdu_valid,
    output logic        psdu_ready,
    input  logic [7:0]  psdu_byte,
    output logic        data_bit_valid,
    output logic        data_bit,
    output logic        busy,
    output logic        done,
    output logic [15:0] n_sym,
    output logic        underrun,
    output logic        rate_err
);

    localparam logic [15:0] SERVICE_LAST = 16'(SERVICE_LEN - 1);
    localparam logic [15:0] TAIL_LAST    = 16'(TAIL_LEN - 1);

    state_t               r_state, w_nextState;
    logic [NDBPS_W-1:0]   r_ndbps, r_symCnt, w_ndbps;
    logic [15:0]          r_phaseCnt, r_bytesLeft, r_fetchLeft, r_nSym;
    logic [2:0]           r_bitIdx;
    logic [7:0]           r_shift, r_buf;
    logic                 r_bufFull, r_underrun, r_rateErr;
    logic                 w_rateOk, w_accept, w_emit, w_symWrap, w_lastBit;
    logic                 w_serviceLast, w_tailLast, w_byteLast;
    logic                 w_load, w_underrunLoad, w_transfer;

    tx_rate_lut u_rate_lut (
        .i_rate    (rate),
        .o_ndbps   (w_ndbps),
        .o_rate_ok (w_rateOk)
    );

    assign w_accept = (r_state == IDLE) && start && w_rateOk;
`ifdef TX_SEQ_PAD_EN
    assign w_emit = (r_state == SERVICE) || (r_state == DATA) || (r_state == TAIL) || (r_state == PAD);
`else
    assign w_emit = (r_state == SERVICE) || (r_state == DATA) || (r_state == TAIL);
`endif
    assign w_symWrap     = w_emit && (r_symCnt == r_ndbps - NDBPS_W'(1));
    assign w_serviceLast = (r_state == SERVICE) && (r_phaseCnt == SERVICE_LAST);
    assign w_tailLast    = (r_state == TAIL) && (r_phaseCnt == TAIL_LAST);
    assign w_byteLast    = (r_state == DATA) && (r_bitIdx == 3'd7);
    assign w_lastBit     = w_emit && (w_nextState == DONE);

    // Shifter reload at every byte boundary; an empty buffer there becomes an underrun byte.
    assign w_load         = (w_serviceLast && (r_bytesLeft != 16'd0)) ||
                            (w_byteLast && (r_bytesLeft > 16'd1));
    assign w_underrunLoad = w_load && !r_bufFull;
    assign psdu_ready     = ((r_state == SERVICE) || (r_state == DATA)) && !r_bufFull &&
                            (r_fetchLeft > {15'd0, w_underrunLoad});
    assign w_transfer     = psdu_valid && psdu_ready;

    always_ff @(posedge clk_Modulation) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = SERVICE;
            SERVICE: if (w_serviceLast) w_nextState = (r_bytesLeft == 16'd0) ? TAIL : DATA;
            DATA:    if (w_byteLast && (r_bytesLeft == 16'd1)) w_nextState = TAIL;
            TAIL: begin
                if (w_tailLast) begin
`ifdef TX_SEQ_PAD_EN
                    w_nextState = w_symWrap ? DONE : PAD;
`else
                    w_nextState = DONE;
`endif
                end
            end
`ifdef TX_SEQ_PAD_EN
            PAD:     if (w_symWrap) w_nextState = DONE;
`endif
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_Modulation) begin
        if (!reset_n) begin
            r_ndbps     <= '0;
            r_symCnt    <= '0;
            r_phaseCnt  <= '0;
            r_bytesLeft <= '0;
            r_fetchLeft <= '0;
            r_nSym      <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_buf       <= '0;
            r_bufFull   <= 1'b0;
            r_underrun  <= 1'b0;
            r_rateErr   <= 1'b0;
        end else if (w_accept) begin
            r_ndbps     <= w_ndbps;
            r_symCnt    <= '0;
            r_phaseCnt  <= '0;
            r_bytesLeft <= packetlength;
            r_fetchLeft <= packetlength;
            r_nSym      <= '0;
            r_bitIdx    <= '0;
            r_bufFull   <= 1'b0;
            r_underrun  <= 1'b0;
            r_rateErr   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) r_rateErr <= 1'b1;
            if (r_state != w_nextState) r_phaseCnt <= '0;
            else if (w_emit)            r_phaseCnt <= r_phaseCnt + 16'd1;
            if (r_state == DATA) r_bitIdx <= r_bitIdx + 3'd1;
            if (w_byteLast) r_bytesLeft <= r_bytesLeft - 16'd1;
            if (w_load)                r_shift <= r_bufFull ? r_buf : 8'h00;
            else if (r_state == DATA)  r_shift <= {1'b0, r_shift[7:1]};
            if (w_transfer) begin
                r_buf     <= psdu_byte;
                r_bufFull <= 1'b1;
            end else if (w_load) begin
                r_bufFull <= 1'b0;
            end
            r_fetchLeft <= r_fetchLeft - {15'd0, w_transfer} - {15'd0, w_underrunLoad};
            if (w_underrunLoad) r_underrun <= 1'b1;
            if (w_emit) r_symCnt <= w_symWrap ? '0 : r_symCnt + NDBPS_W'(1);
            // The final bit always closes a symbol, whether it wraps or leaves a partial one.
            if (w_symWrap || w_lastBit) r_nSym <= r_nSym + 16'd1;
        end
    end

    assign data_bit_valid = w_emit;
    assign data_bit       = (r_state == DATA) && r_shift[0];
    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign n_sym          = r_nSym;
    assign underrun       = r_underrun;
    assign rate_err       = r_rateErr;

endmodule

// File: tb/tb_tx_bit_sequencer.sv
// Randomised self-checking bench for tx_bit_sequencer against a queue-based frame model.
// Expected frame lengths follow TX_SEQ_PAD_EN when it is defined for the build.
module tb_tx_bit_sequencer;

    localparam int SERVICE_LEN = 16;
    localparam int TAIL_LEN    = 6;

    logic        clk = 1'b0;
    logic        reset_n, start, psdu_valid;
    logic [3:0]  rate;
    logic [15:0] packetlength;
    logic [7:0]  psdu_byte;
    logic        psdu_ready, data_bit_valid, data_bit, busy, done, underrun, rate_err;
    logic [15:0] n_sym;

    int checks   = 0;
    int failures = 0;
    int obsLen;

    logic [3:0] validRates [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                                   4'b1001, 4'b1011, 4'b0001, 4'b0011};

    tx_bit_sequencer dut (
        .clk_Modulation (clk),
        .reset_n        (reset_n),
        .start          (start),
        .rate           (rate),
        .packetlength   (packetlength),
        .psdu_valid     (psdu_valid),
        .psdu_ready     (psdu_ready),
        .psdu_byte      (psdu_byte),
        .data_bit_valid (data_bit_valid),
        .data_bit       (data_bit),
        .busy           (busy),
        .done           (done),
        .n_sym          (n_sym),
        .underrun       (underrun),
        .rate_err       (rate_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Data bits per OFDM symbol = 4 x data rate in Mbit/s.
    function automatic int ndbpsOf(input logic [3:0] r);
        case (r)
            4'b1101: return 6 * 4;
            4'b1111: return 9 * 4;
            4'b0101: return 12 * 4;
            4'b0111: return 18 * 4;
            4'b1001: return 24 * 4;
            4'b1011: return 36 * 4;
            4'b0001: return 48 * 4;
            4'b0011: return 54 * 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [22:0] outVec();
        return {data_bit_valid, data_bit, psdu_ready, busy, done, underrun, rate_err, n_sym};
    endfunction

    // One frame: holdSlot withholds the source so that byte slot underruns,
    // midStart pulses start at that frame cycle, startInDone pulses start in the DONE cycle.
    task automatic applyStimulus(input logic [3:0] rt, input int len, input int fixedByte,
                                 input int holdSlot, input int midStart, input bit startInDone,
                                 output int frameLen);
        byte unsigned src[$];
        bit           expBits[$];
        bit           gotBits[$];
        int           ndbps, nBase, nSymExp, fetched, seen, gaps, cyc, limit, bitErrs;
        bit           sawDone, doneValid, doneBusy;
        logic [7:0]   b;

        ndbps = ndbpsOf(rt);
        for (int i = 0; i < len; i++)
            src.push_back((fixedByte >= 0) ? 8'(fixedByte) : 8'($urandom));

        for (int i = 0; i < SERVICE_LEN; i++) expBits.push_back(1'b0);
        for (int k = 0; k < len; k++) begin
            if (k == holdSlot)                   b = 8'h00;
            else if (holdSlot >= 0 && k > holdSlot) b = src[k-1];
            else                                 b = src[k];
            for (int j = 0; j < 8; j++) expBits.push_back(b[j]);
        end
        for (int i = 0; i < TAIL_LEN; i++) expBits.push_back(1'b0);
        nBase   = expBits.size();
        nSymExp = (nBase + ndbps - 1) / ndbps;
`ifdef TX_SEQ_PAD_EN
        while (expBits.size() < nSymExp * ndbps) expBits.push_back(1'b0);
`endif

        @(negedge clk);
        rate         = rt;
        packetlength = 16'(len);
        start        = 1'b1;
        psdu_valid   = 1'b0;
        @(negedge clk);
        start = 1'b0;

        fetched = 0; seen = 0; gaps = 0; cyc = 0;
        sawDone = 1'b0; doneValid = 1'b0; doneBusy = 1'b0;
        limit = expBits.size() + 20;
        while (!sawDone && cyc < limit) begin
            if (done) begin
                sawDone   = 1'b1;
                doneValid = data_bit_valid;
                doneBusy  = busy;
            end else if (data_bit_valid) begin
                gotBits.push_back(data_bit);
                seen++;
            end else begin
                gaps++;
            end
            if (!sawDone) begin
                start = (cyc == midStart);
                if (start) rate = 4'($urandom);
                psdu_valid = (fetched < len) &&
                             !(fetched == holdSlot && seen < SERVICE_LEN + 8 * holdSlot);
                psdu_byte  = (fetched < len) ? src[fetched] : 8'($urandom);
                if (psdu_valid && psdu_ready) fetched++;
                cyc++;
                @(negedge clk);
            end
        end

        psdu_valid = 1'b0;
        start      = startInDone;
        rate       = validRates[$urandom_range(0, 7)];
        @(negedge clk);
        start = 1'b0;

        bitErrs = 0;
        for (int i = 0; i < gotBits.size() && i < expBits.size(); i++)
            if (gotBits[i] != expBits[i]) bitErrs++;

        checkOutput("done_seen", sawDone, 1);
        checkOutput("frame_len", gotBits.size(), expBits.size());
        checkOutput("bit_errors", bitErrs, 0);
        checkOutput("valid_gaps", gaps, 0);
        checkOutput("done_valid", doneValid, 0);
        checkOutput("done_busy", doneBusy, 1);
        checkOutput("n_sym", n_sym, nSymExp);
        checkOutput("underrun", underrun, (holdSlot >= 0) ? 1 : 0);
        checkOutput("rate_err", rate_err, 0);
        checkOutput("idle_after", {busy, done, data_bit_valid}, 3'b000);
        frameLen = gotBits.size();
    endtask

    task automatic applyResetMidFrame();
        int seen, cyc;
        @(negedge clk);
        rate         = 4'b1011;
        packetlength = 16'd10;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 20 && cyc < 200) begin
            if (data_bit_valid) seen++;
            psdu_valid = (seen >= SERVICE_LEN);
            psdu_byte  = 8'($urandom);
            cyc++;
            if (seen < 20) @(negedge clk);
        end
        checkOutput("reach_bit20", seen, 20);
        checkOutput("pre_reset_underrun", underrun, 1);
        reset_n    = 1'b0;
        psdu_valid = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs", outVec(), 0);
        rate  = 4'b1101;
        start = 1'b1;
        @(negedge clk);
        checkOutput("reset_ignores_start", outVec(), 0);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", outVec(), 0);
    endtask

    initial begin
        int vcount, len, hold, mid;
        reset_n      = 1'b0;
        start        = 1'b0;
        rate         = 4'b0000;
        packetlength = 16'd0;
        psdu_valid   = 1'b0;
        psdu_byte    = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", outVec(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_state", outVec(), 0);

        applyStimulus(4'b1101, 1, 8'hA5, -1, -1, 1'b0, obsLen);
`ifdef TX_SEQ_PAD_EN
        checkOutput("a5_total_len", obsLen, 48);
`else
        checkOutput("a5_total_len", obsLen, 30);
`endif
        checkOutput("a5_n_sym", n_sym, 2);

        applyStimulus(4'b0011, 100, -1, -1, -1, 1'b0, obsLen);
`ifdef TX_SEQ_PAD_EN
        checkOutput("r54_total_len", obsLen, 864);
`else
        checkOutput("r54_total_len", obsLen, 822);
`endif
        checkOutput("r54_n_sym", n_sym, 4);

        applyStimulus(4'b0101, 4, -1, 2, -1, 1'b0, obsLen);
`ifdef TX_SEQ_PAD_EN
        checkOutput("under_total_len", obsLen, 96);
`else
        checkOutput("under_total_len", obsLen, 54);
`endif

        @(negedge clk);
        rate  = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rate_err_set", rate_err, 1);
        checkOutput("rate_err_busy", busy, 0);
        vcount = 0;
        repeat (4) begin
            if (data_bit_valid) vcount++;
            @(negedge clk);
        end
        checkOutput("rate_err_no_valid", vcount, 0);
        applyStimulus(4'b0111, 2, -1, -1, -1, 1'b0, obsLen);

        applyResetMidFrame();
        applyStimulus(4'b1011, 10, -1, -1, -1, 1'b0, obsLen);

        applyStimulus(4'b1001, 3, -1, -1, 5, 1'b1, obsLen);

        for (int f = 0; f < 14; f++) begin
            len  = $urandom_range(0, 24);
            hold = (len > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            mid  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SERVICE_LEN + 8 * len + TAIL_LEN - 1)) : -1;
            applyStimulus(validRates[$urandom_range(0, 7)], len, -1, hold, mid,
                          1'($urandom_range(0, 1)), obsLen);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
